// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares a true-dual-port block RAM between two requesters.
// After reset the RAM is swept to zero two words per cycle (INIT); afterwards
// (RUN) requester A drives RAM port A and requester B drives RAM port B, with a
// rotating priority resolving same-address conflicts involving a write.
// Optional feature: define BRAM_ARB_STATS_EN to add a saturating 16-bit
// conflict counter output (conflict_cnt).
module bram_port_arbiter #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024,  // must be even
  parameter int LOG       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [LOG-1:0]       a_addr,
  input  logic [RAM_WIDTH-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [RAM_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [LOG-1:0]       b_addr,
  input  logic [RAM_WIDTH-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [RAM_WIDTH-1:0] b_rdata,
  output logic                 ram_wrena,
  output logic                 ram_rdena,
  output logic [LOG-1:0]       ram_addra,
  output logic [RAM_WIDTH-1:0] ram_dina,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  output logic                 ram_wrenb,
  output logic                 ram_rdenb,
  output logic [LOG-1:0]       ram_addrb,
  output logic [RAM_WIDTH-1:0] ram_dinb,
  input  logic [RAM_WIDTH-1:0] ram_doutb,
`ifdef BRAM_ARB_STATS_EN
  output logic [15:0]          conflict_cnt,
`endif
  output logic                 init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [LOG-1:0] SWEEP_LAST = LOG'(RAM_DEPTH / 2 - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [LOG-1:0] r_sweep;
  logic           r_prio_b;      // 0: A holds priority, 1: B holds priority
  logic           r_init_done;
  logic           r_a_rvalid;
  logic           r_b_rvalid;

  logic           w_run;
  logic           w_sweep_last;
  logic [LOG-1:0] w_sweep_addr_a;
  logic [LOG-1:0] w_sweep_addr_b;
  logic           w_conflict;
  logic           w_run_conflict;
  logic           w_a_gnt;
  logic           w_b_gnt;

  assign w_run          = (r_state == ST_RUN);
  assign w_sweep_last   = (r_sweep == SWEEP_LAST);
  // Sweep word pair k covers addresses 2k (port A) and 2k+1 (port B).
  assign w_sweep_addr_a = {r_sweep[LOG-2:0], 1'b0};
  assign w_sweep_addr_b = {r_sweep[LOG-2:0], 1'b1};

  assign w_conflict     = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);
  assign w_run_conflict = w_run & w_conflict;
  // Reset forces INIT asynchronously, so grants drop the moment rst_n falls.
  assign w_a_gnt        = w_run & a_req & (~w_conflict | ~r_prio_b);
  assign w_b_gnt        = w_run & b_req & (~w_conflict |  r_prio_b);

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = ram_douta;
  assign b_rdata   = ram_doutb;
  assign init_done = r_init_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave INIT after the last word pair is written; RUN is terminal.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && w_sweep_last) w_state_nxt = ST_RUN;
  end

  // Sweep counter advances once per INIT cycle and parks on the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_sweep <= '0;
    else if (r_state == ST_INIT && !w_sweep_last) r_sweep <= r_sweep + LOG'(1);
  end

  // RAM port drive: zero sweep during INIT, per-requester pass-through in RUN.
  always_comb begin
    ram_wrena = 1'b0;
    ram_rdena = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    ram_wrenb = 1'b0;
    ram_rdenb = 1'b0;
    ram_addrb = '0;
    ram_dinb  = '0;
    if (r_state == ST_INIT) begin
      ram_wrena = rst_n;
      ram_wrenb = rst_n;
      ram_addra = w_sweep_addr_a;
      ram_addrb = w_sweep_addr_b;
    end else begin
      ram_wrena = w_a_gnt &  a_we;
      ram_rdena = w_a_gnt & ~a_we;
      ram_addra = a_addr;
      ram_dina  = a_wdata;
      ram_wrenb = w_b_gnt &  b_we;
      ram_rdenb = w_b_gnt & ~b_we;
      ram_addrb = b_addr;
      ram_dinb  = b_wdata;
    end
  end

  // Priority passes to the losing side after each conflict cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_prio_b <= 1'b0;
    else if (w_run_conflict) r_prio_b <= ~r_prio_b;
  end

  // Read-valid flags track the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt & a_req & ~a_we;
      r_b_rvalid <= w_b_gnt & b_req & ~b_we;
    end
  end

  // init_done goes high together with the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else        r_init_done <= (w_state_nxt == ST_RUN);
  end

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of conflict cycles seen in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_conflict_cnt <= '0;
    else if (w_run_conflict && r_conflict_cnt != '1)   r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: behavioural dual-port RAM plus directed and
// randomized scenarios checked against a specification-level model.
module tb_bram_port_arbiter;
  localparam int W = 16;
  localparam int D = 1024;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [L-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0] a_wdata = '0, b_wdata = '0;
  logic         a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [W-1:0] a_rdata, b_rdata;
  logic         ram_wrena, ram_rdena, ram_wrenb, ram_rdenb;
  logic [L-1:0] ram_addra, ram_addrb;
  logic [W-1:0] ram_dina, ram_dinb;
  logic [W-1:0] ram_douta = '0, ram_doutb = '0;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]  conflict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural RAM with a bench-side preload port.
  logic [W-1:0] ram [0:D-1];
  logic         tb_we = 1'b0;
  logic [L-1:0] tb_addr = '0;
  logic [W-1:0] tb_data = '0;

  // Reference model state.
  logic [W-1:0] m_mem [0:D-1];
  logic         m_prio;
  int           m_cnt;

  // Observed values captured by drive().
  logic         obs_agnt, obs_bgnt, obs_wa, obs_ra, obs_wb, obs_rb, obs_arv, obs_brv;
  logic [L-1:0] obs_addra, obs_addrb;
  logic [W-1:0] obs_dina, obs_dinb, obs_ard, obs_brd;
  logic [15:0]  obs_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we)     ram[tb_addr]   <= tb_data;
    if (ram_wrena) ram[ram_addra] <= ram_dina;
    if (ram_wrenb) ram[ram_addrb] <= ram_dinb;
    if (ram_rdena) ram_douta <= ram[ram_addra];
    if (ram_rdenb) ram_doutb <= ram[ram_addrb];
  end

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LOG(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wrena(ram_wrena), .ram_rdena(ram_rdena), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta),
    .ram_wrenb(ram_wrenb), .ram_rdenb(ram_rdenb), .ram_addrb(ram_addrb),
    .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
`ifdef BRAM_ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .init_done(init_done)
  );

  // Watchdog: the run must never hang.
  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
  endtask

  // Apply one request cycle (called at a falling edge); capture combinational
  // outputs before the rising edge and registered outputs after it.
  task automatic drive(input logic ar, input logic aw, input logic [L-1:0] aa, input logic [W-1:0] ad,
                       input logic br, input logic bw, input logic [L-1:0] ba, input logic [W-1:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    obs_agnt = a_gnt; obs_bgnt = b_gnt;
    obs_wa = ram_wrena; obs_ra = ram_rdena; obs_wb = ram_wrenb; obs_rb = ram_rdenb;
    obs_addra = ram_addra; obs_addrb = ram_addrb; obs_dina = ram_dina; obs_dinb = ram_dinb;
    @(posedge clk);
    @(negedge clk);
    obs_arv = a_rvalid; obs_brv = b_rvalid; obs_ard = a_rdata; obs_brd = b_rdata;
`ifdef BRAM_ARB_STATS_EN
    obs_cnt = conflict_cnt;
`else
    obs_cnt = 16'h0;
`endif
  endtask

  task automatic reset_and_init();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (D / 2) @(negedge clk);
  endtask

  function automatic logic [L-1:0] pick_addr();
    int t;
    t = $urandom_range(0, 9);
    if (t < 8)       return L'(t);
    else if (t == 8) return L'(D - 2);
    else             return L'(D - 1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < D; i++) begin
      tb_we = 1'b1; tb_addr = L'(i); tb_data = W'($urandom);
      @(negedge clk);
    end
    tb_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b1; a_addr = 10'd3; b_addr = 10'd4;
    #1;
    vectors++;
    if ({a_gnt, b_gnt, ram_wrena, ram_rdena, ram_wrenb, ram_rdenb, a_rvalid, b_rvalid, init_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {a_gnt, b_gnt, ram_wrena, ram_rdena, ram_wrenb, ram_rdenb, a_rvalid, b_rvalid, init_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < D / 2; k++) begin
      #1;
      vectors++;
      if ({ram_addra, ram_addrb} !== {L'(2 * k), L'(2 * k + 1)} || {ram_dina, ram_dinb} !== '0) begin
        miscompares++;
        $display("FAIL sweep_addr k=%0d: got a=%0d b=%0d dina=%h dinb=%h want a=%0d b=%0d din=0",
                 k, ram_addra, ram_addrb, ram_dina, ram_dinb, 2 * k, 2 * k + 1);
      end
      vectors++;
      if ({ram_wrena, ram_wrenb, ram_rdena, ram_rdenb, a_gnt, b_gnt, init_done} !== 7'b1100000) begin
        miscompares++;
        $display("FAIL sweep_ctrl k=%0d: got %b want 1100000", k,
                 {ram_wrena, ram_wrenb, ram_rdena, ram_rdenb, a_gnt, b_gnt, init_done});
      end
      @(negedge clk);
    end
    idle();
    #1;
    vectors++;
    if (init_done !== 1'b1) begin miscompares++; $display("FAIL init_done_rise: got %b want 1", init_done); end
    drive(1'b1, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd511, 16'h0);
    vectors++;
    if ({obs_agnt, obs_bgnt, obs_arv, obs_brv} !== 4'b1111 || obs_ard !== 16'h0 || obs_brd !== 16'h0) begin
      miscompares++;
      $display("FAIL clear_0_511: got flags=%b a=%h b=%h want flags=1111 a=0000 b=0000",
               {obs_agnt, obs_bgnt, obs_arv, obs_brv}, obs_ard, obs_brd);
    end
    drive(1'b1, 1'b0, 10'd1023, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    vectors++;
    if ({obs_arv, obs_brv} !== 2'b10 || obs_ard !== 16'h0) begin
      miscompares++;
      $display("FAIL clear_1023: got rv=%b a=%h want rv=10 a=0000", {obs_arv, obs_brv}, obs_ard);
    end
    idle();
  endtask

  task automatic test_random();
    logic         ar, aw, br, bw, ea, eb, conf, a_pend, b_pend;
    logic [L-1:0] aa, ba;
    logic [W-1:0] ad, bd, rda, rdb;
    reset_and_init();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_prio = 1'b0; m_cnt = 0;
    a_pend = 1'b0; b_pend = 1'b0;
    ar = 1'b0; aw = 1'b0; br = 1'b0; bw = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int n = 0; n < 800; n++) begin
      if (!a_pend) begin
        ar = ($urandom_range(0, 3) != 0); aw = 1'($urandom_range(0, 1)); aa = pick_addr(); ad = W'($urandom);
      end
      if (!b_pend) begin
        br = ($urandom_range(0, 3) != 0); bw = 1'($urandom_range(0, 1)); ba = pick_addr(); bd = W'($urandom);
      end
      conf = ar && br && (aa == ba) && (aw || bw);
      ea = ar && (!conf || m_prio == 1'b0);
      eb = br && (!conf || m_prio == 1'b1);
      rda = m_mem[aa]; rdb = m_mem[ba];
      drive(ar, aw, aa, ad, br, bw, ba, bd);
      vectors++;
      if ({obs_agnt, obs_bgnt} !== {ea, eb}) begin
        miscompares++;
        $display("FAIL rnd_gnt n=%0d: got %b want %b", n, {obs_agnt, obs_bgnt}, {ea, eb});
      end
      vectors++;
      if ({obs_wa, obs_ra, obs_wb, obs_rb} !== {ea & aw, ea & ~aw, eb & bw, eb & ~bw}) begin
        miscompares++;
        $display("FAIL rnd_en n=%0d: got %b want %b", n, {obs_wa, obs_ra, obs_wb, obs_rb},
                 {ea & aw, ea & ~aw, eb & bw, eb & ~bw});
      end
      if (ea) begin
        vectors++;
        if (obs_addra !== aa || (aw && obs_dina !== ad)) begin
          miscompares++;
          $display("FAIL rnd_porta n=%0d: got addr=%0d din=%h want addr=%0d din=%h", n, obs_addra, obs_dina, aa, ad);
        end
      end
      if (eb) begin
        vectors++;
        if (obs_addrb !== ba || (bw && obs_dinb !== bd)) begin
          miscompares++;
          $display("FAIL rnd_portb n=%0d: got addr=%0d din=%h want addr=%0d din=%h", n, obs_addrb, obs_dinb, ba, bd);
        end
      end
      vectors++;
      if ({obs_arv, obs_brv} !== {ea & ~aw, eb & ~bw}) begin
        miscompares++;
        $display("FAIL rnd_rvalid n=%0d: got %b want %b", n, {obs_arv, obs_brv}, {ea & ~aw, eb & ~bw});
      end
      if (ea && !aw) begin
        vectors++;
        if (obs_ard !== rda) begin miscompares++; $display("FAIL rnd_rdata_a n=%0d: got %h want %h", n, obs_ard, rda); end
      end
      if (eb && !bw) begin
        vectors++;
        if (obs_brd !== rdb) begin miscompares++; $display("FAIL rnd_rdata_b n=%0d: got %h want %h", n, obs_brd, rdb); end
      end
      if (ea && aw) m_mem[aa] = ad;
      if (eb && bw) m_mem[ba] = bd;
      if (conf) begin
        m_prio = ~m_prio;
        if (m_cnt < 65535) m_cnt++;
      end
`ifdef BRAM_ARB_STATS_EN
      vectors++;
      if (obs_cnt !== 16'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt n=%0d: got %0d want %0d", n, obs_cnt, m_cnt); end
`endif
      a_pend = ar && !ea;
      b_pend = br && !eb;
    end
    idle();
  endtask

  task automatic test_write_read();
    reset_and_init();
    drive(1'b1, 1'b1, 10'd5, 16'hBEEF, 1'b1, 1'b0, 10'd7, 16'h0);
    vectors++;
    if ({obs_agnt, obs_bgnt, obs_wa, obs_ra, obs_wb, obs_rb} !== 6'b111001) begin
      miscompares++;
      $display("FAIL wr_grant: got %b want 111001", {obs_agnt, obs_bgnt, obs_wa, obs_ra, obs_wb, obs_rb});
    end
    vectors++;
    if ({obs_arv, obs_brv} !== 2'b01 || obs_brd !== 16'h0) begin
      miscompares++;
      $display("FAIL wr_b_read7: got rv=%b b=%h want rv=01 b=0000", {obs_arv, obs_brv}, obs_brd);
    end
    drive(1'b1, 1'b0, 10'd5, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    vectors++;
    if ({obs_agnt, obs_arv, obs_brv} !== 3'b110 || obs_ard !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL wr_readback: got flags=%b a=%h want flags=110 a=beef", {obs_agnt, obs_arv, obs_brv}, obs_ard);
    end
    idle();
  endtask

  task automatic test_conflict();
    reset_and_init();
    drive(1'b1, 1'b1, 10'd9, 16'h1111, 1'b1, 1'b1, 10'd9, 16'h2222);
    vectors++;
    if ({obs_agnt, obs_bgnt, obs_wa, obs_wb} !== 4'b1010) begin
      miscompares++;
      $display("FAIL conf_cycle1: got %b want 1010", {obs_agnt, obs_bgnt, obs_wa, obs_wb});
    end
    drive(1'b1, 1'b1, 10'd9, 16'h1111, 1'b1, 1'b1, 10'd9, 16'h2222);
    vectors++;
    if ({obs_agnt, obs_bgnt, obs_wa, obs_wb} !== 4'b0101) begin
      miscompares++;
      $display("FAIL conf_cycle2: got %b want 0101", {obs_agnt, obs_bgnt, obs_wa, obs_wb});
    end
`ifdef BRAM_ARB_STATS_EN
    vectors++;
    if (obs_cnt !== 16'd2) begin miscompares++; $display("FAIL conf_cnt: got %0d want 2", obs_cnt); end
`endif
    drive(1'b1, 1'b0, 10'd9, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    vectors++;
    if (obs_arv !== 1'b1 || obs_ard !== 16'h2222) begin
      miscompares++;
      $display("FAIL conf_readback: got rv=%b a=%h want rv=1 a=2222", obs_arv, obs_ard);
    end
    idle();
  endtask

  task automatic test_dual_read();
    reset_and_init();
    drive(1'b1, 1'b1, 10'd3, 16'h5A5A, 1'b0, 1'b0, 10'd0, 16'h0);
    drive(1'b1, 1'b0, 10'd3, 16'h0, 1'b1, 1'b0, 10'd3, 16'h0);
    vectors++;
    if ({obs_agnt, obs_bgnt, obs_arv, obs_brv} !== 4'b1111) begin
      miscompares++;
      $display("FAIL dual_flags: got %b want 1111", {obs_agnt, obs_bgnt, obs_arv, obs_brv});
    end
    vectors++;
    if (obs_ard !== 16'h5A5A || obs_brd !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL dual_data: got a=%h b=%h want 5a5a", obs_ard, obs_brd);
    end
`ifdef BRAM_ARB_STATS_EN
    vectors++;
    if (obs_cnt !== 16'd0) begin miscompares++; $display("FAIL dual_cnt: got %0d want 0", obs_cnt); end
`endif
    // Priority must still be with A after non-conflict traffic.
    drive(1'b1, 1'b0, 10'd3, 16'h0, 1'b1, 1'b1, 10'd3, 16'h7777);
    vectors++;
    if ({obs_agnt, obs_bgnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL dual_prio_kept: got %b want 10", {obs_agnt, obs_bgnt});
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    vectors++;
    if ({init_done, ram_addra} !== {1'b0, 10'd400}) begin
      miscompares++;
      $display("FAIL mid_sweep_pos: got done=%b addr=%0d want done=0 addr=400", init_done, ram_addra);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ram_wrena, ram_rdena, ram_wrenb, ram_rdenb, a_gnt, b_gnt, init_done} !== 7'b0) begin
      miscompares++;
      $display("FAIL mid_sweep_rst: got %b want 0000000",
               {ram_wrena, ram_rdena, ram_wrenb, ram_rdenb, a_gnt, b_gnt, init_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < D / 2; k++) begin
      #1;
      vectors++;
      if ({init_done, ram_addra} !== {1'b0, L'(2 * k)}) begin
        miscompares++;
        $display("FAIL resweep k=%0d: got done=%b addr=%0d want done=0 addr=%0d", k, init_done, ram_addra, 2 * k);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (init_done !== 1'b1) begin miscompares++; $display("FAIL resweep_done: got %b want 1", init_done); end
  endtask

  task automatic test_reset_mid_run();
    reset_and_init();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd0;
    @(posedge clk);
    #1;
    vectors++;
    if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL midrun_rvalid_pre: got %b want 1", a_rvalid); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_rvalid, a_gnt, ram_rdena, init_done} !== 4'b0) begin
      miscompares++;
      $display("FAIL midrun_abort: got %b want 0000", {a_rvalid, a_gnt, ram_rdena, init_done});
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({ram_wrena, ram_addra} !== {1'b1, 10'd0}) begin
      miscompares++;
      $display("FAIL midrun_restart: got wren=%b addr=%0d want wren=1 addr=0", ram_wrena, ram_addra);
    end
    @(negedge clk);
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_saturation();
    reset_and_init();
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd9; a_wdata = 16'h1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'd9; b_wdata = 16'h2;
    repeat (65534) @(negedge clk);
    vectors++;
    if (conflict_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h want fffe", conflict_cnt); end
    @(negedge clk);
    vectors++;
    if (conflict_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit: got %h want ffff", conflict_cnt); end
    repeat (70000 - 65535) @(negedge clk);
    vectors++;
    if (conflict_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    idle();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_random();
    test_write_read();
    test_conflict();
    test_dual_read();
    test_reset_mid_sweep();
    test_reset_mid_run();
`ifdef BRAM_ARB_STATS_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
